// File: rtl/npu_result_packer.sv
// Realigns skewed systolic column outputs into rows, requantizes each row to int8,
// packs it into one DMA word and queues it in a show-ahead FIFO with flow-control status.
module npu_result_packer #(
  parameter int N          = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int AXI_WIDTH  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [4:0]                   cfg_shift,
  input  logic                         cfg_round,
  input  logic                         cfg_relu,
  input  logic [N*ACC_WIDTH-1:0]       core_y_out,
  input  logic [N-1:0]                 core_valid_out,
  output logic [AXI_WIDTH-1:0]         dma_data_out,
  output logic                         dma_data_out_valid,
  input  logic                         dma_data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         almost_full,
  output logic                         overflow,
  output logic                         skew_err,
  output logic [31:0]                  rows_out
);

  localparam int EW = ACC_WIDTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic signed [EW-1:0] Q_MAX = EW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] Q_MIN = ~Q_MAX;

  // Rounding shift, saturation and optional ReLU on one accumulator.
  function automatic logic [OUT_WIDTH-1:0] requant(
    input logic [ACC_WIDTH-1:0] y,
    input logic [4:0]           shift,
    input logic                 round_en,
    input logic                 relu_en
  );
    logic signed [EW-1:0] v;
    logic [EW-1:0]        bias;
    logic [OUT_WIDTH-1:0] res;
    bias = '0;
    if (round_en && shift != 5'd0) bias = EW'(1) << (shift - 5'd1);
    v = signed'({y[ACC_WIDTH-1], y}) + signed'(bias);
    v = v >>> shift;
    if (v > Q_MAX)      res = Q_MAX[OUT_WIDTH-1:0];
    else if (v < Q_MIN) res = Q_MIN[OUT_WIDTH-1:0];
    else                res = v[OUT_WIDTH-1:0];
    if (relu_en && v[EW-1]) res = '0;
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Deskew: column j lags column 0 by j cycles, so it gets N-j delay stages and
  // every column of a row lands at stage A in the same cycle.
  // ---------------------------------------------------------------------------
  logic [N-1:0][ACC_WIDTH-1:0] a_data;
  logic [N-1:0]                a_valid;

  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - j;
    logic [D-1:0]         v_q;
    logic [ACC_WIDTH-1:0] d_q [D];

    // NOTE: sequential state is written with <= so every stage samples the
    // pre-edge value of its neighbour; = here would collapse the delay line.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= '0;
      end else if (clear) begin
        v_q <= '0;
      end else begin
        v_q[0] <= core_valid_out[j];
        for (int k = 1; k < D; k++) v_q[k] <= v_q[k-1];
      end
    end

    // NOTE: data registers and the FIFO array are deliberately not reset; the
    // valid bits and pointers qualify them, and a reset array costs real muxing.
    always_ff @(posedge clk) begin
      d_q[0] <= core_y_out[j*ACC_WIDTH +: ACC_WIDTH];
      for (int k = 1; k < D; k++) d_q[k] <= d_q[k-1];
    end

    assign a_valid[j] = v_q[D-1];
    assign a_data[j]  = d_q[D-1];
  end

  logic row_all;
  logic row_partial;

  assign row_all     = &a_valid;
  assign row_partial = (|a_valid) && !row_all;

  // ---------------------------------------------------------------------------
  // Stage Q: requantize and pack, column 0 in the least significant byte.
  // ---------------------------------------------------------------------------
  logic [AXI_WIDTH-1:0] q_data_d, q_data_q;
  logic                 q_valid_q;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    q_data_d = '0;
    for (int j = 0; j < N; j++) begin
      q_data_d[j*OUT_WIDTH +: OUT_WIDTH] = requant(a_data[j], cfg_shift, cfg_round, cfg_relu);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q_valid_q <= 1'b0;
    else if (clear) q_valid_q <= 1'b0;
    else            q_valid_q <= row_all;
  end

  always_ff @(posedge clk) begin
    q_data_q <= q_data_d;
  end

  // ---------------------------------------------------------------------------
  // Output FIFO and sticky status.
  // ---------------------------------------------------------------------------
  logic [AXI_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_d, wr_ptr_q;
  logic [PW-1:0]        rd_ptr_d, rd_ptr_q;
  logic [LW-1:0]        level_d, level_q;
  logic                 overflow_d, overflow_q;
  logic                 skew_err_d, skew_err_q;
  logic [31:0]          rows_d, rows_q;
  logic                 pop;
  logic                 push;
  logic                 drop;

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign pop  = (level_q != '0) && dma_data_out_ready;
  assign push = q_valid_q && ((level_q < LW'(FIFO_DEPTH)) || pop);
  assign drop = q_valid_q && !push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rows_d     = rows_q;
    overflow_d = overflow_q | drop;
    skew_err_d = skew_err_q | row_partial;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      rows_d   = rows_q + 32'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rows_d     = '0;
      overflow_d = 1'b0;
      skew_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rows_q     <= '0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rows_q     <= rows_d;
      overflow_q <= overflow_d;
      skew_err_q <= skew_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= q_data_q;
  end

  assign dma_data_out_valid = (level_q != '0);
  assign dma_data_out       = dma_data_out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level         = level_q;
  assign almost_full        = (level_q >= LW'(FIFO_DEPTH - N - 2));
  assign overflow           = overflow_q;
  assign skew_err           = skew_err_q;
  assign rows_out           = rows_q;

endmodule
